// File: rtl/nios_copy_pkg.sv
// Shared types and constants for the Avalon-MM memory copy master.
package nios_copy_pkg;

    // Copy engine FSM states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        FINISH  = 3'd4
    } copy_state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [3:0] BE_ALL         = 4'hF;
    localparam logic [3:0] BE_NONE        = 4'h0;

endpackage

// File: rtl/nios_mem_copy_master_if.sv
// Avalon-MM master/slave signal bundle for a 32-bit single-port memory slave.
interface nios_mem_copy_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;
    logic              avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        input  avm_readdata,
        input  avm_readdatavalid,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        output avm_readdata,
        output avm_readdatavalid,
        output avm_waitrequest
    );
endinterface

// File: rtl/nios_mem_copy_master.sv
// Avalon-MM block copy master: one read/write pair per 32-bit word, at most
// one outstanding read. All bus outputs come straight from flops.
module nios_mem_copy_master
    import nios_copy_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 13
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        src_addr,
    input  logic [ADDR_W-1:0]        dst_addr,
    input  logic [LEN_W-1:0]         len_words,
    output logic                     busy,
    output logic                     done,
    nios_mem_copy_master_if.master   avm
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BYTES_PER_WORD);
    localparam logic [LEN_W-1:0]  LEN_ZERO   = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]  LEN_ONE    = LEN_W'(1);

    copy_state_e       state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [3:0]        be_q, be_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // State, pointer, data and registered-output flops; reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            src_q   <= {ADDR_W{1'b0}};
            dst_q   <= {ADDR_W{1'b0}};
            rem_q   <= LEN_ZERO;
            wdata_q <= 32'h0000_0000;
            addr_q  <= {ADDR_W{1'b0}};
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= BE_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            be_q    <= be_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic plus pointer/counter/data-capture updates.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d = src_addr & ALIGN_MASK;
                    dst_d = dst_addr & ALIGN_MASK;
                    rem_d = len_words;
                    if (len_words == LEN_ZERO) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                if (!avm.avm_waitrequest) begin
                    // Zero-latency slaves may return data with the accept.
                    if (avm.avm_readdatavalid) begin
                        wdata_d = avm.avm_readdata;
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else begin
                    state_d = RD_REQ;
                end
            end
            RD_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    wdata_d = avm.avm_readdata;
                    state_d = WR_REQ;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            WR_REQ: begin
                if (!avm.avm_waitrequest) begin
                    src_d = src_q + ADDR_STEP;
                    dst_d = dst_q + ADDR_STEP;
                    rem_d = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_d = FINISH;
                    end else begin
                        state_d = RD_REQ;
                    end
                end else begin
                    state_d = WR_REQ;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so that every output is a flop.
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        addr_d = {ADDR_W{1'b0}};
        be_d   = BE_NONE;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            RD_REQ: begin
                busy_d = 1'b1;
                rd_d   = 1'b1;
                addr_d = src_d;
                be_d   = BE_ALL;
            end
            RD_WAIT: begin
                busy_d = 1'b1;
                addr_d = src_d;
            end
            WR_REQ: begin
                busy_d = 1'b1;
                wr_d   = 1'b1;
                addr_d = dst_d;
                be_d   = BE_ALL;
            end
            FINISH: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_read       = rd_q;
    assign avm.avm_write      = wr_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;

endmodule
